decode_queue: RTL and testbench
===============================

// Module: decode_queue
// PURPOSE
// Multi-lane decode buffer between fetch and issue. Accepts up to FETCH_WIDTH instructions/cycle.
// Decodes each one to operation_t (MIPS32 opcode map from cpu.svh) on enqueue, stores it in a circular queue,
// and presents up to ISSUE_WIDTH decoded ops/cycle in program order.
// Keeps a branch/jump and its delay slot in the same issue group.
// PARAMETERS
// FETCH_WIDTH  2  instructions offered per cycle (1..4)
// ISSUE_WIDTH  2  max ops presented per cycle (1..4)
// DEPTH        8  queue entries; power of two, >= FETCH_WIDTH+ISSUE_WIDTH
// PORTS
// clk        in   1                  clock, all state on rising edge
// rst        in   1                  asynchronous, active-high reset
// flush      in   1                  synchronous clear of all queued entries
// in_valid   in   FETCH_WIDTH        per-lane valid; lane 0 = oldest
// in_inst    in   FETCH_WIDTH x 32   instruction words
// in_pc      in   FETCH_WIDTH x 32   instruction addresses
// in_ready   out  1                  queue can take a full FETCH_WIDTH group this cycle
// out_valid  out  ISSUE_WIDTH        per-slot valid, contiguous from slot 0
// out_op     out  ISSUE_WIDTH x op_t decoded operation; OP_INVALID when slot not valid
// out_inst   out  ISSUE_WIDTH x 32   raw instruction word of slot
// out_pc     out  ISSUE_WIDTH x 32   pc of slot
// out_ready  in   1                  consumer takes every valid slot this cycle
// count      out  $clog2(DEPTH)+1    occupied entries
// BEHAVIOUR
// - Reset: head=tail=0, count=0, out_valid=0, out_op=OP_INVALID, out_inst/out_pc=0, in_ready=1.
// - in_ready = (DEPTH - count) >= FETCH_WIDTH. Uses registered count; same-cycle dequeue is not credited.
// - Enqueue when in_ready & in_valid[0]. Accepts the contiguous valid prefix of lanes.
//   Lanes after the first invalid lane are dropped. Offers with in_ready=0 are ignored; fetch must hold them.
// - Decode is combinational at the input; op, inst and pc are written together into the entry.
//   Undefined encodings are stored as OP_INVALID and issued normally; downstream raises RI.
// - Latency: instruction enqueued in cycle N is visible on out_* in cycle N+1 if it is the oldest entry.
// - Presentation: slots 0..k-1 = oldest k entries, k = min(count, ISSUE_WIDTH), then the delay-slot rule is applied.
// - Control class: J, JAL, JR, JALR, BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, BLTZAL, BGEZAL.
// - Delay-slot rule (ISSUE_WIDTH>1 only): if slot k-1 holds a control op, k is reduced by 1.
//   If that makes k=0 (lone branch at head, count=1), out_valid=0 until its delay slot is enqueued.
//   The branch then issues together with the delay slot.
// - ISSUE_WIDTH=1: rule disabled; one op per cycle.
// - Dequeue when out_ready & out_valid[0]: head += k (mod DEPTH).
//   out_ready with out_valid=0 has no effect.
// - Simultaneous enqueue and dequeue: count_next = count + accepted - k. Pointers wrap modulo DEPTH.
// - Full (count=DEPTH): in_ready=0; dequeue still allowed.
// - Empty: out_valid=0.
// - flush: next cycle count=0, head=tail=0, out_valid=0.
//   Flush has priority; enqueue and dequeue in the flush cycle are discarded.
// - rst asserted mid-operation clears state immediately (asynchronous); queued entries are lost.
// TESTING
// - Reset, then offer 2 lanes 0x24020005 (addiu), 0x00000000 (sll) -> next cycle out_valid=2'b11,
//   out_op={OP_ADDIU,OP_SLL}, count=2.
// - Offer beq 0x10220003 alone (lane1 invalid) -> out_valid=0 for >=3 cycles.
//   Then enqueue nop -> next cycle slots {OP_BEQ,OP_SLL} valid together.
// - Queue holds addiu, jr 0x03E00008, nop -> first group presents only addiu (k=1).
//   After dequeue, {OP_JR,OP_SLL} presented.
// - Fill to DEPTH=8 with out_ready=0 -> in_ready=0 once count>6, count saturates at 8.
//   Drain with out_ready=1 -> head wraps to 0, order preserved.
// - Assert flush while enqueuing and out_ready=1 -> next cycle count=0, out_valid=0, no entry consumed.
// - Encoding 0xFC000000 -> presented with out_op=OP_INVALID, out_valid=1.
//   Assert rst mid-stream -> count=0 and out_valid=0 in the same cycle.

Source files
------------

// File: rtl/decode_queue.sv
// Multi-lane decode buffer between fetch and issue: decodes MIPS32 words on enqueue,
// holds them in a circular queue and presents up to ISSUE_WIDTH ops in program order.
package decode_queue_pkg;
  typedef enum logic [5:0] {
    OP_INVALID, OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV,
    OP_JR, OP_JALR, OP_SYSCALL, OP_BREAK, OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO,
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_ADD, OP_ADDU, OP_SUB, OP_SUBU,
    OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_BLTZ, OP_BGEZ, OP_BLTZAL, OP_BGEZAL,
    OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
    OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW
  } op_t;
endpackage

module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [FETCH_WIDTH-1:0]        in_valid,
  input  logic [FETCH_WIDTH-1:0][31:0]  in_inst,
  input  logic [FETCH_WIDTH-1:0][31:0]  in_pc,
  output logic                          in_ready,
  output logic [ISSUE_WIDTH-1:0]        out_valid,
  output op_t  [ISSUE_WIDTH-1:0]        out_op,
  output logic [ISSUE_WIDTH-1:0][31:0]  out_inst,
  output logic [ISSUE_WIDTH-1:0][31:0]  out_pc,
  input  logic                          out_ready,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - FETCH_WIDTH);
  localparam logic [CW-1:0] IW_C      = CW'(ISSUE_WIDTH);

  function automatic op_t decode(input logic [31:0] w);
    op_t op;
    op = OP_INVALID;
    case (w[31:26])
      6'h00: begin
        case (w[5:0])
          6'h00: op = OP_SLL;     6'h02: op = OP_SRL;     6'h03: op = OP_SRA;
          6'h04: op = OP_SLLV;    6'h06: op = OP_SRLV;    6'h07: op = OP_SRAV;
          6'h08: op = OP_JR;      6'h09: op = OP_JALR;
          6'h0C: op = OP_SYSCALL; 6'h0D: op = OP_BREAK;
          6'h10: op = OP_MFHI;    6'h11: op = OP_MTHI;
          6'h12: op = OP_MFLO;    6'h13: op = OP_MTLO;
          6'h18: op = OP_MULT;    6'h19: op = OP_MULTU;
          6'h1A: op = OP_DIV;     6'h1B: op = OP_DIVU;
          6'h20: op = OP_ADD;     6'h21: op = OP_ADDU;
          6'h22: op = OP_SUB;     6'h23: op = OP_SUBU;
          6'h24: op = OP_AND;     6'h25: op = OP_OR;
          6'h26: op = OP_XOR;     6'h27: op = OP_NOR;
          6'h2A: op = OP_SLT;     6'h2B: op = OP_SLTU;
          default: op = OP_INVALID;
        endcase
      end
      6'h01: begin
        case (w[20:16])
          5'h00: op = OP_BLTZ;    5'h01: op = OP_BGEZ;
          5'h10: op = OP_BLTZAL;  5'h11: op = OP_BGEZAL;
          default: op = OP_INVALID;
        endcase
      end
      6'h02: op = OP_J;     6'h03: op = OP_JAL;
      6'h04: op = OP_BEQ;   6'h05: op = OP_BNE;
      6'h06: op = OP_BLEZ;  6'h07: op = OP_BGTZ;
      6'h08: op = OP_ADDI;  6'h09: op = OP_ADDIU;
      6'h0A: op = OP_SLTI;  6'h0B: op = OP_SLTIU;
      6'h0C: op = OP_ANDI;  6'h0D: op = OP_ORI;
      6'h0E: op = OP_XORI;  6'h0F: op = OP_LUI;
      6'h20: op = OP_LB;    6'h21: op = OP_LH;
      6'h23: op = OP_LW;    6'h24: op = OP_LBU;
      6'h25: op = OP_LHU;   6'h28: op = OP_SB;
      6'h29: op = OP_SH;    6'h2B: op = OP_SW;
      default: op = OP_INVALID;
    endcase
    return op;
  endfunction

  function automatic logic is_ctrl(input op_t op);
    return op inside {OP_J, OP_JAL, OP_JR, OP_JALR, OP_BEQ, OP_BNE, OP_BLEZ,
                      OP_BGTZ, OP_BLTZ, OP_BGEZ, OP_BLTZAL, OP_BGEZAL};
  endfunction

  op_t               op_q   [DEPTH];
  logic [31:0]       inst_q [DEPTH];
  logic [31:0]       pc_q   [DEPTH];
  logic [DEPTH-1:0]  ctrl_q;
  logic [PW-1:0]     head, tail, last_idx;
  logic [CW-1:0]     n_acc, avail, k;
  logic              run, deq;
  op_t               lane_op [FETCH_WIDTH];

  assign in_ready = (count <= READY_MAX);
  assign deq      = out_ready && (k != '0);

  // Accept only the contiguous valid prefix of the fetch group.
  always_comb begin
    n_acc = '0;
    run   = 1'b1;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      lane_op[i] = decode(in_inst[i]);
      if (run && in_valid[i]) n_acc = n_acc + 1'b1;
      else                    run   = 1'b0;
    end
    if (!in_ready) n_acc = '0;
  end

  // Hold back a trailing branch so it always issues with its delay slot.
  always_comb begin
    avail    = (count < IW_C) ? count : IW_C;
    last_idx = head + PW'(avail - 1'b1);
    k        = avail;
    if (ISSUE_WIDTH > 1 && avail != '0 && ctrl_q[last_idx]) k = avail - 1'b1;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      out_valid[i] = 1'b0;
      out_op[i]    = OP_INVALID;
      out_inst[i]  = '0;
      out_pc[i]    = '0;
      if (CW'(i) < k) begin
        out_valid[i] = 1'b1;
        out_op[i]    = op_q[head + PW'(i)];
        out_inst[i]  = inst_q[head + PW'(i)];
        out_pc[i]    = pc_q[head + PW'(i)];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (deq) head <= head + PW'(k);
      tail  <= tail + PW'(n_acc);
      count <= count + n_acc - (deq ? k : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (CW'(i) < n_acc) begin
          op_q[tail + PW'(i)]   <= lane_op[i];
          inst_q[tail + PW'(i)] <= in_inst[i];
          pc_q[tail + PW'(i)]   <= in_pc[i];
          ctrl_q[tail + PW'(i)] <= is_ctrl(lane_op[i]);
        end
      end
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Randomized bench for decode_queue against a queue-based reference model that
// applies the presentation, delay-slot, flush and reset rules directly.
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int FW    = 2;
  localparam int IW    = 2;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int NT    = 22;

  localparam logic [31:0] TW [NT] = '{
    32'h24020005, 32'h00000000, 32'h10220003, 32'h03E00008, 32'hFC000000,
    32'h08000010, 32'h0C000010, 32'h14220001, 32'h0411FFFF, 32'h04100002,
    32'h00221820, 32'h8C430004, 32'h3C01ABCD, 32'h00430821, 32'h0000000C,
    32'h7C000000, 32'h00000001, 32'h18400002, 32'h1C400002, 32'h04000002,
    32'h04010002, 32'h0000F809};
  localparam op_t TO [NT] = '{
    OP_ADDIU, OP_SLL, OP_BEQ, OP_JR, OP_INVALID,
    OP_J, OP_JAL, OP_BNE, OP_BGEZAL, OP_BLTZAL,
    OP_ADD, OP_LW, OP_LUI, OP_ADDU, OP_SYSCALL,
    OP_INVALID, OP_INVALID, OP_BLEZ, OP_BGTZ, OP_BLTZ,
    OP_BGEZ, OP_JALR};

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    op_t         op;
    bit          ctrl;
  } ent_t;

  logic                  clk = 1'b0;
  logic                  rst, flush, in_ready, out_ready;
  logic [FW-1:0]         in_valid;
  logic [FW-1:0][31:0]   in_inst, in_pc;
  logic [IW-1:0]         out_valid;
  op_t  [IW-1:0]         out_op;
  logic [IW-1:0][31:0]   out_inst, out_pc;
  logic [CW-1:0]         count;

  op_t  lane_op [FW];
  ent_t mq [$];
  int   n_checks = 0;
  int   n_errors = 0;

  decode_queue #(.FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_ready(in_ready),
    .out_valid(out_valid), .out_op(out_op), .out_inst(out_inst), .out_pc(out_pc),
    .out_ready(out_ready), .count(count));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit branch_class(input op_t op);
    case (op)
      OP_J, OP_JAL, OP_JR, OP_JALR, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
      OP_BLTZ, OP_BGEZ, OP_BLTZAL, OP_BGEZAL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int exp_k();
    int k;
    k = (mq.size() < IW) ? mq.size() : IW;
    if (IW > 1 && k > 0 && mq[k-1].ctrl) k--;
    return k;
  endfunction

  task automatic compare_all();
    int k;
    logic [IW-1:0] ev;
    k  = exp_k();
    ev = '0;
    for (int i = 0; i < k; i++) ev[i] = 1'b1;
    check("count", 64'(count), 64'(mq.size()));
    check("in_ready", 64'(in_ready), 64'((DEPTH - mq.size()) >= FW));
    check("out_valid", 64'(out_valid), 64'(ev));
    for (int i = 0; i < IW; i++) begin
      if (i < k) begin
        check("out_op", 64'(out_op[i]), 64'(mq[i].op));
        check("out_inst", 64'(out_inst[i]), 64'(mq[i].inst));
        check("out_pc", 64'(out_pc[i]), 64'(mq[i].pc));
      end else begin
        check("out_op_idle", 64'(out_op[i]), 64'(OP_INVALID));
        check("out_inst_idle", 64'(out_inst[i]), 64'd0);
        check("out_pc_idle", 64'(out_pc[i]), 64'd0);
      end
    end
  endtask

  task automatic set_lane(input int l, input int idx);
    in_valid[l] = 1'b1;
    in_inst[l]  = TW[idx];
    in_pc[l]    = $urandom & 32'hFFFF_FFFC;
    lane_op[l]  = TO[idx];
  endtask

  task automatic idle_lanes();
    in_valid = '0;
    in_inst  = '0;
    in_pc    = '0;
    for (int l = 0; l < FW; l++) lane_op[l] = OP_INVALID;
  endtask

  // Advance one clock, update the model with the inputs applied, then compare.
  task automatic step();
    int k;
    bit rdy, run;
    k   = exp_k();
    rdy = (DEPTH - mq.size()) >= FW;
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      if (out_ready && k > 0) repeat (k) void'(mq.pop_front());
      if (rdy && in_valid[0]) begin
        run = 1'b1;
        for (int i = 0; i < FW; i++) begin
          if (run && in_valid[i]) begin
            ent_t e;
            e.inst = in_inst[i];
            e.pc   = in_pc[i];
            e.op   = lane_op[i];
            e.ctrl = branch_class(lane_op[i]);
            mq.push_back(e);
          end else run = 1'b0;
        end
      end
    end
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    idle_lanes();
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b0;

    // Two-lane group visible next cycle.
    set_lane(0, 0); set_lane(1, 1);
    step();
    check("t1_op0", 64'(out_op[0]), 64'(OP_ADDIU));
    check("t1_op1", 64'(out_op[1]), 64'(OP_SLL));
    idle_lanes(); out_ready = 1'b1;
    step();

    // Lone branch waits for its delay slot.
    out_ready = 1'b0;
    set_lane(0, 2);
    step();
    idle_lanes(); out_ready = 1'b1;
    repeat (3) begin
      step();
      check("t2_stall", 64'(out_valid), 64'd0);
    end
    out_ready = 1'b0;
    set_lane(0, 1);
    step();
    check("t2_pair_valid", 64'(out_valid), 64'h3);
    check("t2_pair_op0", 64'(out_op[0]), 64'(OP_BEQ));
    check("t2_pair_op1", 64'(out_op[1]), 64'(OP_SLL));
    idle_lanes(); out_ready = 1'b1;
    step();

    // addiu, jr, nop: jr must not issue without its slot.
    out_ready = 1'b0;
    set_lane(0, 0); set_lane(1, 3);
    step();
    idle_lanes(); set_lane(0, 1);
    step();
    check("t3_k1", 64'(out_valid), 64'h1);
    idle_lanes(); out_ready = 1'b1;
    step();
    check("t3_jr", 64'(out_op[0]), 64'(OP_JR));
    check("t3_nop", 64'(out_op[1]), 64'(OP_SLL));
    step();

    // Fill to full, then drain across the wrap point.
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      set_lane(0, 10 + (c % 4)); set_lane(1, 11 + (c % 3));
      step();
    end
    check("t4_full", 64'(count), 64'(DEPTH));
    check("t4_not_ready", 64'(in_ready), 64'd0);
    idle_lanes(); out_ready = 1'b1;
    repeat (5) step();

    // Flush wins over enqueue and dequeue.
    out_ready = 1'b0;
    set_lane(0, 12); set_lane(1, 13);
    step();
    flush = 1'b1; out_ready = 1'b1;
    set_lane(0, 0); set_lane(1, 1);
    step();
    check("t5_flush_cnt", 64'(count), 64'd0);
    check("t5_flush_vld", 64'(out_valid), 64'd0);
    flush = 1'b0;
    idle_lanes();
    step();

    // Undefined encoding flows through, then asynchronous reset mid-stream.
    out_ready = 1'b0;
    set_lane(0, 4);
    step();
    check("t6_inv_op", 64'(out_op[0]), 64'(OP_INVALID));
    check("t6_inv_vld", 64'(out_valid), 64'h1);
    idle_lanes(); set_lane(0, 0); set_lane(1, 1);
    step();
    idle_lanes();
    #2 rst = 1'b1;
    #1;
    check("t6_rst_cnt", 64'(count), 64'd0);
    check("t6_rst_vld", 64'(out_valid), 64'd0);
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
    compare_all();

    // Randomized traffic.
    for (int c = 0; c < 800; c++) begin
      idle_lanes();
      for (int l = 0; l < FW; l++)
        if ($urandom_range(0, 3) != 0) set_lane(l, $urandom_range(0, NT - 1));
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 39) == 0);
      step();
    end
    flush = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
